// File: rtl/flag_branch_ctrl.sv
// flag_branch_ctrl
//   Sequences the 4-bit NZVC flag register and resolves B.cond branches in ID.
//   Drives the flag register write select, stalls ID for one cycle on a flag
//   hazard (EX sets flags while ID holds a B.cond), and issues taken-branch
//   and IF/ID flush control.
//
//   Optional feature macro: FLAG_FWD_EN
//     defined   -> ALU flags are forwarded to the branch evaluation on a
//                  hazard, so no hazard stall ever occurs.
//     undefined -> every hazard costs one stall cycle (HOLD state).
//
// Parameters
//   CNT_W        width of the saturating flag-stall counter
//   FLUSH_CYCLES cycles flush is held after a taken branch (1..7)
//
// Ports
//   clk          system clock, all state on posedge
//   reset        asynchronous, active-high reset
//   id_valid     valid instruction in ID
//   id_bcond     ID instruction is B.cond
//   id_cond      condition field of the B.cond in ID
//   ex_valid     valid instruction in EX
//   ex_setflags  EX instruction sets flags
//   alu_flags    ALU flags this cycle: [0]N [1]Z [2]V [3]C
//   flags_q      flag register output, same bit order
//   flag_we      flag register write select (1 = load alu_flags)
//   stall        hold PC and IF/ID, insert bubble into EX
//   br_taken     B.cond resolved taken, 1-cycle pulse
//   flush        squash IF/ID
//   stall_cnt    number of flag-hazard stall cycles (saturating)
module flag_branch_ctrl #(
    parameter int CNT_W        = 16,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic             id_bcond,
    input  logic [3:0]       id_cond,
    input  logic             ex_valid,
    input  logic             ex_setflags,
    input  logic [3:0]       alu_flags,
    input  logic [3:0]       flags_q,
    output logic             flag_we,
    output logic             stall,
    output logic             br_taken,
    output logic             flush,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [2:0] FlushLoad = 3'(FLUSH_CYCLES);

    state_t     state;
    state_t     stateNext;
    logic [2:0] flushCnt;
    logic [2:0] flushCntNext;

    logic       hz;
    logic       hzStall;
    logic [3:0] effFlags;
    logic       stallInt;
    logic       brInt;
    logic       flushInt;

    // Flags are packed [0]N [1]Z [2]V [3]C.
    function automatic logic condTrue(input logic [3:0] c, input logic [3:0] f);
        logic n, z, v, cy;
        n  = f[0];
        z  = f[1];
        v  = f[2];
        cy = f[3];
        case (c)
            4'd0:    condTrue = z;
            4'd1:    condTrue = !z;
            4'd2:    condTrue = cy;
            4'd3:    condTrue = !cy;
            4'd4:    condTrue = n;
            4'd5:    condTrue = !n;
            4'd6:    condTrue = v;
            4'd7:    condTrue = !v;
            4'd8:    condTrue = cy && !z;
            4'd9:    condTrue = !cy || z;
            4'd10:   condTrue = (n == v);
            4'd11:   condTrue = (n != v);
            4'd12:   condTrue = !z && (n == v);
            4'd13:   condTrue = z || (n != v);
            default: condTrue = 1'b1;   // AL and NV both always execute
        endcase
    endfunction

    assign hz = id_valid & id_bcond & ex_valid & ex_setflags;

`ifdef FLAG_FWD_EN
    // Forwarded flags resolve the hazard in place; the stall path is dead.
    assign effFlags = hz ? alu_flags : flags_q;
    assign hzStall  = 1'b0;
`else
    // alu_flags only reaches the flag register externally in this build.
    logic unusedAluFlags;
    assign unusedAluFlags = ^alu_flags;
    assign effFlags       = flags_q;
    assign hzStall        = hz;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RUN;
            flushCnt <= '0;
        end else begin
            state    <= stateNext;
            flushCnt <= flushCntNext;
        end
    end

    always_comb begin
        stateNext    = state;
        flushCntNext = flushCnt;
        stallInt     = 1'b0;
        brInt        = 1'b0;
        flushInt     = 1'b0;
        case (state)
            RUN: begin
                if (hzStall) begin
                    stallInt  = 1'b1;
                    stateNext = HOLD;
                end else if (id_valid && id_bcond) begin
                    if (condTrue(id_cond, effFlags)) begin
                        brInt        = 1'b1;
                        flushCntNext = FlushLoad;
                        stateNext    = FLUSH;
                    end
                end
            end
            HOLD: begin
                // IF/ID was held, so id_cond still belongs to the stalled
                // B.cond; flags_q now carries the EX result.
                if (condTrue(id_cond, flags_q)) begin
                    brInt        = 1'b1;
                    flushCntNext = FlushLoad;
                    stateNext    = FLUSH;
                end else begin
                    stateNext = RUN;
                end
            end
            FLUSH: begin
                flushInt = 1'b1;
                if (flushCnt <= 3'd1) begin
                    flushCntNext = '0;
                    stateNext    = RUN;
                end else begin
                    flushCntNext = flushCnt - 3'd1;
                end
            end
            default: begin
                stateNext    = RUN;
                flushCntNext = '0;
            end
        endcase
    end

    // Outputs are forced low for the whole reset assertion, not just after
    // the state register clears, since RUN outputs follow the ID/EX inputs.
    assign flag_we  = ex_valid & ex_setflags & ~reset;
    assign stall    = stallInt & ~reset;
    assign br_taken = brInt & ~reset;
    assign flush    = flushInt & ~reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stallInt && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_flag_branch_ctrl.sv
`timescale 1ns/1ps
module tb_flag_branch_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

`ifdef FLAG_FWD_EN
    localparam logic HZS = 1'b0;
`else
    localparam logic HZS = 1'b1;
`endif

    logic        reset;
    logic        idValid, idBcond, exValid, exSetflags;
    logic [3:0]  idCond, aluFlags, flagsQ;
    logic        flagWe, stall, brTaken, flush;
    logic [15:0] stallCnt;

    logic        bIdValid, bIdBcond, bExValid, bExSetflags;
    logic [3:0]  bIdCond, bAluFlags, bFlagsQ;
    logic        bFlagWe, bStall, bBrTaken, bFlush;
    logic [1:0]  bStallCnt;

    flag_branch_ctrl #(.CNT_W(16), .FLUSH_CYCLES(2)) dut (
        .clk(clk), .reset(reset),
        .id_valid(idValid), .id_bcond(idBcond), .id_cond(idCond),
        .ex_valid(exValid), .ex_setflags(exSetflags),
        .alu_flags(aluFlags), .flags_q(flagsQ),
        .flag_we(flagWe), .stall(stall), .br_taken(brTaken),
        .flush(flush), .stall_cnt(stallCnt)
    );

    flag_branch_ctrl #(.CNT_W(2), .FLUSH_CYCLES(1)) dut2 (
        .clk(clk), .reset(reset),
        .id_valid(bIdValid), .id_bcond(bIdBcond), .id_cond(bIdCond),
        .ex_valid(bExValid), .ex_setflags(bExSetflags),
        .alu_flags(bAluFlags), .flags_q(bFlagsQ),
        .flag_we(bFlagWe), .stall(bStall), .br_taken(bBrTaken),
        .flush(bFlush), .stall_cnt(bStallCnt)
    );

    typedef struct {
        logic        fwe;
        logic        st;
        logic        br;
        logic        fl;
        logic [15:0] cnt;
        logic        st2;
        logic [1:0]  cnt2;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    logic [15:0] expCnt  = '0;
    logic [1:0]  expCnt2 = '0;

    // Reference truth table: pairs of codes share a base test, odd codes
    // invert it; AL/NV always pass.
    function automatic logic refCond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, v, cy, base;
        n = f[0]; z = f[1]; v = f[2]; cy = f[3];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy & ~z;
            3'd5: base = ~(n ^ v);
            3'd6: base = ~z & ~(n ^ v);
            default: base = 1'b1;
        endcase
        if (c[3:1] == 3'd7) refCond = 1'b1;
        else                refCond = c[0] ? ~base : base;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] ex);
        total++;
        assert (obs === ex) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, ex);
        end
    endtask

    task automatic drv(input logic iv, input logic bc, input logic [3:0] c,
                       input logic ev, input logic es, input logic [3:0] alu,
                       input logic [3:0] fq);
        idValid = iv; idBcond = bc; idCond = c;
        exValid = ev; exSetflags = es; aluFlags = alu; flagsQ = fq;
    endtask

    task automatic drv2(input logic iv, input logic bc, input logic [3:0] c,
                        input logic ev, input logic es, input logic [3:0] alu,
                        input logic [3:0] fq);
        bIdValid = iv; bIdBcond = bc; bIdCond = c;
        bExValid = ev; bExSetflags = es; bAluFlags = alu; bFlagsQ = fq;
    endtask

    task automatic step(input logic fwe, input logic st, input logic br,
                        input logic fl, input logic st2);
        exp_t e;
        exp_t got;
        e.fwe = fwe; e.st = st; e.br = br; e.fl = fl;
        e.cnt = expCnt; e.st2 = st2; e.cnt2 = expCnt2;
        sb.push_back(e);
        @(negedge clk);
        got = sb.pop_front();
        chk("flag_we",   16'(flagWe),    16'(got.fwe));
        chk("stall",     16'(stall),     16'(got.st));
        chk("br_taken",  16'(brTaken),   16'(got.br));
        chk("flush",     16'(flush),     16'(got.fl));
        chk("stall_cnt", stallCnt,       got.cnt);
        chk("stall2",    16'(bStall),    16'(got.st2));
        chk("stall_cnt2",16'(bStallCnt), 16'(got.cnt2));
        if (got.st && expCnt != 16'hFFFF) expCnt++;
        if (got.st2 && expCnt2 != 2'b11) expCnt2++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic t;
        reset = 1'b1;
        drv2(0, 0, 0, 0, 0, 0, 0);
        drv(1, 1, 4'd0, 1, 1, 4'hF, 4'h2);
        #1;
        // reset holds every output low, including flag_we
        step(0, 0, 0, 0, 0);
        reset = 1'b0;

        // EQ with Z set, no hazard: taken now, flush for 2 following cycles
        drv(1, 1, 4'd0, 0, 0, 4'h0, 4'b0010); step(0, 0, 1, 0, 0);
        drv(0, 0, 4'd0, 0, 0, 4'h0, 4'b0010); step(0, 0, 0, 1, 0);
        // hazard during FLUSH is ignored
        drv(1, 1, 4'd14, 1, 1, 4'h1, 4'b0010); step(1, 0, 0, 1, 0);
        // NE with Z set: not taken, no flush
        drv(1, 1, 4'd1, 0, 0, 4'h0, 4'b0010); step(0, 0, 0, 0, 0);
        drv(0, 0, 4'd0, 0, 0, 4'h0, 4'b0010); step(0, 0, 0, 0, 0);
        // id_bcond without id_valid: no action
        drv(0, 1, 4'd14, 0, 0, 4'h0, 4'h0);   step(0, 0, 0, 0, 0);

        // SUBS sets N, B.LT in ID
        drv(1, 1, 4'd11, 1, 1, 4'b0001, 4'h0);
`ifdef FLAG_FWD_EN
        step(1, 0, 1, 0, 0);
        drv(1, 1, 4'd11, 0, 0, 4'h0, 4'b0001); step(0, 0, 0, 1, 0);
        drv(0, 0, 4'd0, 0, 0, 4'h0, 4'b0001);  step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
`else
        step(1, 1, 0, 0, 0);
        drv(1, 1, 4'd11, 0, 0, 4'h0, 4'b0001); step(0, 0, 1, 0, 0);
        drv(0, 0, 4'd0, 0, 0, 4'h0, 4'b0001);  step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
`endif

        // B.GE after SUBS giving N: not taken, then B.MI right behind it
        drv(1, 1, 4'd10, 1, 1, 4'b0001, 4'h0); step(1, HZS, 0, 0, 0);
        drv(1, 1, 4'd10, 0, 0, 4'h0, 4'b0001); step(0, 0, 0, 0, 0);
        drv(1, 1, 4'd4, 0, 0, 4'h0, 4'b0001);  step(0, 0, 1, 0, 0);

        // reset asserted mid-FLUSH with a hazard presented
        reset = 1'b1;
        expCnt = '0;
        expCnt2 = '0;
        drv(1, 1, 4'd0, 1, 1, 4'h2, 4'h2);     step(0, 0, 0, 0, 0);
        reset = 1'b0;
        drv(1, 1, 4'd0, 0, 0, 4'h0, 4'b0010);  step(0, 0, 1, 0, 0);
        drv(0, 0, 4'd0, 0, 0, 4'h0, 4'h0);     step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);

        // condition x flags sweep, no hazard
        for (int c = 0; c < 16; c++) begin
            for (int f = 0; f < 16; f++) begin
                t = refCond(4'(c), 4'(f));
                drv(1, 1, 4'(c), 0, 0, 4'h0, 4'(f));
                step(0, 0, t, 0, 0);
                if (t) begin
                    drv(0, 0, 4'd0, 0, 0, 4'h0, 4'h0);
                    step(0, 0, 0, 1, 0);
                    step(0, 0, 0, 1, 0);
                end
            end
        end

        // 2-bit counter: four hazards, B.EQ never taken (Z clear)
        drv(0, 0, 4'd0, 0, 0, 4'h0, 4'h0);
        for (int k = 0; k < 4; k++) begin
            drv2(1, 1, 4'd0, 1, 1, 4'h0, 4'h0); step(0, 0, 0, 0, HZS);
            drv2(1, 1, 4'd0, 0, 0, 4'h0, 4'h0); step(0, 0, 0, 0, 0);
        end
        drv2(0, 0, 4'd0, 0, 0, 4'h0, 4'h0);
        step(0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
